// File: rtl/fifo_ctrl.sv
// Pointer control for a synchronous FIFO: accepts requests, derives flags/count from counter pointers.
// Flags and count are combinational; rvalid, sticky errors and the shadow pointer check are registered.
module fifo_ctrl #(
  parameter int ADDR_W   = 3,
  parameter int PTR_W    = ADDR_W + 1,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic              fc_clk,
  input  logic              fc_clear,
  input  logic              fc_wr,
  input  logic              fc_rd,
  input  logic [PTR_W-1:0]  fc_wptr,
  input  logic [PTR_W-1:0]  fc_rptr,
  output logic              fc_we,
  output logic              fc_re,
  output logic [ADDR_W-1:0] fc_waddr,
  output logic [ADDR_W-1:0] fc_raddr,
  output logic              fc_full,
  output logic              fc_empty,
  output logic              fc_afull,
  output logic              fc_aempty,
  output logic [PTR_W-1:0]  fc_count,
  output logic              fc_rvalid,
  output logic              fc_ovf,
  output logic              fc_udf,
  output logic              fc_ptr_err
);

  localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(AE_LEVEL);

  logic [PTR_W-1:0] count;
  logic             full;
  logic             empty;
  logic             we;
  logic             re;

  logic             rvalid_q,  rvalid_d;
  logic             ovf_q,     ovf_d;
  logic             udf_q,     udf_d;
  logic             ptr_err_q, ptr_err_d;
  logic [PTR_W-1:0] exp_w_q,   exp_w_d;
  logic [PTR_W-1:0] exp_r_q,   exp_r_d;

  // The extra wrap bit distinguishes full from empty when the address bits match.
  always_comb begin
    count = fc_wptr - fc_rptr;
    empty = (fc_wptr == fc_rptr);
    full  = (fc_wptr[PTR_W-1] != fc_rptr[PTR_W-1]) &&
            (fc_wptr[ADDR_W-1:0] == fc_rptr[ADDR_W-1:0]);
    we    = fc_wr & ~full  & ~fc_clear;
    re    = fc_rd & ~empty & ~fc_clear;
  end

  always_comb begin
    rvalid_d  = re;
    ovf_d     = ovf_q | (fc_wr & full);
    udf_d     = udf_q | (fc_rd & empty);
    exp_w_d   = exp_w_q + PTR_W'(we);
    exp_r_d   = exp_r_q + PTR_W'(re);
    ptr_err_d = ptr_err_q | (fc_wptr != exp_w_q) | (fc_rptr != exp_r_q);
  end

  always_ff @(posedge fc_clk) begin
    if (fc_clear) begin
      rvalid_q  <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      ptr_err_q <= 1'b0;
      exp_w_q   <= '0;
      exp_r_q   <= '0;
    end else begin
      rvalid_q  <= rvalid_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      ptr_err_q <= ptr_err_d;
      exp_w_q   <= exp_w_d;
      exp_r_q   <= exp_r_d;
    end
  end

  assign fc_we      = we;
  assign fc_re      = re;
  assign fc_waddr   = fc_wptr[ADDR_W-1:0];
  assign fc_raddr   = fc_rptr[ADDR_W-1:0];
  assign fc_full    = full;
  assign fc_empty   = empty;
  assign fc_count   = count;
  assign fc_afull   = (count >= AF_LVL);
  assign fc_aempty  = (count <= AE_LVL);
  assign fc_rvalid  = rvalid_q;
  assign fc_ovf     = ovf_q;
  assign fc_udf     = udf_q;
  assign fc_ptr_err = ptr_err_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: local pointer counters, an occupancy-level reference model,
// a directed fill/drain table, hand-written corner sequences and a randomized run.
module tb_fifo_ctrl;

  localparam int DEPTH = 8;

  logic       fc_clk = 1'b0;
  logic       fc_clear, fc_wr, fc_rd;
  logic [3:0] fc_wptr, fc_rptr;
  logic       fc_we, fc_re;
  logic [2:0] fc_waddr, fc_raddr;
  logic       fc_full, fc_empty, fc_afull, fc_aempty;
  logic [3:0] fc_count;
  logic       fc_rvalid, fc_ovf, fc_udf, fc_ptr_err;
  logic       inject;

  fifo_ctrl dut (
    .fc_clk(fc_clk), .fc_clear(fc_clear), .fc_wr(fc_wr), .fc_rd(fc_rd),
    .fc_wptr(fc_wptr), .fc_rptr(fc_rptr), .fc_we(fc_we), .fc_re(fc_re),
    .fc_waddr(fc_waddr), .fc_raddr(fc_raddr), .fc_full(fc_full), .fc_empty(fc_empty),
    .fc_afull(fc_afull), .fc_aempty(fc_aempty), .fc_count(fc_count),
    .fc_rvalid(fc_rvalid), .fc_ovf(fc_ovf), .fc_udf(fc_udf), .fc_ptr_err(fc_ptr_err)
  );

  always #5 fc_clk = ~fc_clk;

  // Stand-ins for the two pointer counters; inject adds a spurious write-pointer step.
  always @(posedge fc_clk) begin
    if (fc_clear) begin
      fc_wptr <= 4'd0;
      fc_rptr <= 4'd0;
    end else begin
      fc_wptr <= fc_wptr + {3'b000, fc_we} + {3'b000, inject};
      fc_rptr <= fc_rptr + {3'b000, fc_re};
    end
  end

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Reference model: occupancy and total operation counts, plus sticky status.
  int occ = 0, wtot = 0, rtot = 0;
  bit m_rvalid = 0, m_ovf = 0, m_udf = 0, m_perr = 0, drift = 0;
  bit cur_wr, cur_rd, cur_clr, cur_inj;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit wr, input bit rd, input bit clr, input bit inj);
    bit e_we, e_re;
    @(negedge fc_clk);
    fc_wr = wr; fc_rd = rd; fc_clear = clr; inject = inj;
    cur_wr = wr; cur_rd = rd; cur_clr = clr; cur_inj = inj;
    #1;
    if (check_en) begin
      e_we = wr && !clr && (occ != DEPTH);
      e_re = rd && !clr && (occ != 0);
      chk("we",      fc_we,      e_we);
      chk("re",      fc_re,      e_re);
      chk("count",   fc_count,   occ);
      chk("empty",   fc_empty,   occ == 0);
      chk("full",    fc_full,    occ == DEPTH);
      chk("afull",   fc_afull,   occ >= 6);
      chk("aempty",  fc_aempty,  occ <= 2);
      chk("waddr",   fc_waddr,   wtot % DEPTH);
      chk("raddr",   fc_raddr,   rtot % DEPTH);
      chk("rvalid",  fc_rvalid,  m_rvalid);
      chk("ovf",     fc_ovf,     m_ovf);
      chk("udf",     fc_udf,     m_udf);
      chk("ptr_err", fc_ptr_err, m_perr);
    end
  endtask

  task automatic edge_upd();
    bit a_we, a_re;
    @(posedge fc_clk);
    a_we = cur_wr && !cur_clr && (occ != DEPTH);
    a_re = cur_rd && !cur_clr && (occ != 0);
    if (cur_clr) begin
      occ = 0; wtot = 0; rtot = 0;
      m_rvalid = 0; m_ovf = 0; m_udf = 0; m_perr = 0; drift = 0;
    end else begin
      if (cur_wr && occ == DEPTH) m_ovf = 1;
      if (cur_rd && occ == 0)     m_udf = 1;
      if (drift) m_perr = 1;
      if (cur_inj) begin
        drift = 1;
        occ++; wtot++;
      end
      occ  = occ + int'(a_we) - int'(a_re);
      wtot = wtot + int'(a_we);
      rtot = rtot + int'(a_re);
      m_rvalid = a_re;
    end
  endtask

  task automatic step(input bit wr, input bit rd, input bit clr);
    drive(wr, rd, clr, 1'b0);
    edge_upd();
  endtask

  typedef struct {
    bit wr, rd;
    bit we, re;
    int cnt;
    bit full, empty;
  } vec_t;

  vec_t vecs[18];

  initial begin
    fc_wr = 0; fc_rd = 0; fc_clear = 0; inject = 0;
    // Fill 9 writes (last one overflows), then drain 9 reads (last one underflows).
    for (int i = 0; i < 9; i++)
      vecs[i] = '{wr: 1, rd: 0, we: (i < 8), re: 0, cnt: i, full: (i == 8), empty: (i == 0)};
    for (int j = 0; j < 9; j++)
      vecs[9 + j] = '{wr: 0, rd: 1, we: 0, re: (j < 8), cnt: 8 - j, full: (j == 0), empty: (j == 8)};

    step(0, 0, 1);
    check_en = 1'b1;
    step(0, 0, 0);

    for (int k = 0; k < 18; k++) begin
      drive(vecs[k].wr, vecs[k].rd, 1'b0, 1'b0);
      chk("tbl_we",    fc_we,    vecs[k].we);
      chk("tbl_re",    fc_re,    vecs[k].re);
      chk("tbl_count", fc_count, vecs[k].cnt);
      chk("tbl_full",  fc_full,  vecs[k].full);
      chk("tbl_empty", fc_empty, vecs[k].empty);
      if (k == 8) begin
        chk("wptr_at_full", fc_wptr, 8);
        chk("rptr_at_full", fc_rptr, 0);
      end
      edge_upd();
    end
    drive(0, 0, 0, 0);
    chk("ovf_sticky", fc_ovf, 1);
    chk("udf_sticky", fc_udf, 1);
    edge_upd();

    // Steady state at occupancy 4 with both pointers wrapping.
    step(0, 0, 1);
    repeat (4) step(1, 0, 0);
    repeat (20) step(1, 1, 0);
    drive(0, 0, 0, 0);
    chk("steady_count", fc_count, 4);
    chk("steady_perr",  fc_ptr_err, 0);
    edge_upd();

    // Full with both requests, then empty with both requests.
    repeat (4) step(1, 0, 0);
    step(1, 1, 0);
    drive(0, 0, 0, 0);
    chk("full_rw_count", fc_count, 7);
    edge_upd();
    repeat (7) step(0, 1, 0);
    step(1, 1, 0);
    drive(0, 0, 0, 0);
    chk("empty_rw_count", fc_count, 1);
    edge_upd();

    // Clear mid-operation with sticky flags set and a read just accepted.
    step(0, 0, 1);
    step(0, 1, 0);
    repeat (9) step(1, 0, 0);
    repeat (3) step(0, 1, 0);
    step(0, 1, 0);
    drive(0, 1, 1, 0);
    chk("clr_re", fc_re, 0);
    edge_upd();
    drive(0, 0, 0, 0);
    chk("clr_count",  fc_count,  0);
    chk("clr_rvalid", fc_rvalid, 0);
    chk("clr_ovf",    fc_ovf,    0);
    edge_upd();

    // Spurious write-pointer advance with no accepted write.
    drive(0, 0, 0, 1);
    edge_upd();
    step(0, 0, 0);
    drive(0, 0, 0, 0);
    chk("perr_set", fc_ptr_err, 1);
    edge_upd();
    repeat (3) step(0, 0, 0);
    step(0, 0, 1);
    drive(0, 0, 0, 0);
    chk("perr_cleared", fc_ptr_err, 0);
    edge_upd();

    // Randomized traffic with shifting write/read bias and rare clears.
    for (int n = 0; n < 3000; n++) begin
      int wb, rb;
      wb = ((n / 100) % 3 == 0) ? 80 : (((n / 100) % 3 == 1) ? 20 : 50);
      rb = 100 - wb;
      step($urandom_range(0, 99) < wb, $urandom_range(0, 99) < rb, $urandom_range(0, 199) == 0);
    end
    step(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
